// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids
// and a small helper used by the round-robin pointer.
package memory_arbiter_pkg;

    typedef enum logic {ST_CLEAR, ST_SERVE} state_e;
    typedef enum logic {REQ_A, REQ_B} req_id_e;

    function automatic req_id_e other_req(req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of client request/response, clear-control and memory-bus signals.
// The slave modport is the arbiter's view; master is the client/memory side.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);
    logic                  clr_start;
    logic                  busy;

    logic                  a_valid;
    logic                  a_write;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ready;
    logic                  a_rvalid;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_valid;
    logic                  b_write;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ready;
    logic                  b_rvalid;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic [DATA_WIDTH-1:0] mem_data_out;

    modport slave (
        input  clr_start,
        input  a_valid, a_write, a_addr, a_wdata,
        input  b_valid, b_write, b_addr, b_wdata,
        input  mem_data_out,
        output busy,
        output a_ready, a_rvalid, a_rdata,
        output b_ready, b_rvalid, b_rdata,
        output mem_read, mem_write, mem_addr, mem_data_in
    );

    modport master (
        output clr_start,
        output a_valid, a_write, a_addr, a_wdata,
        output b_valid, b_write, b_addr, b_wdata,
        output mem_data_out,
        input  busy,
        input  a_ready, a_rvalid, a_rdata,
        input  b_ready, b_rvalid, b_rdata,
        input  mem_read, mem_write, mem_addr, mem_data_in
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. The pointer moves to the requester that was not
// served whenever a grant is issued, so a lone requester never starves the other.
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    req_id_e rr_ptr;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (en) begin
            if (req_a && req_b) begin
                gnt_a = (rr_ptr == REQ_A);
                gnt_b = (rr_ptr == REQ_B);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= REQ_A;
        end else if (gnt_a) begin
            rr_ptr <= other_req(REQ_A);
        end else if (gnt_b) begin
            rr_ptr <= other_req(REQ_B);
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port synchronous memory between requesters A and B with
// round-robin arbitration, 1-cycle read return and a zero-fill clear sweep.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              rst,
    memory_arbiter_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  serve_en;
    logic                  gnt_a, gnt_b;
    logic                  rd_acc;
    logic                  rd_vld_p1;
    req_id_e               rd_id_p1;

    // Grants are suppressed in reset, during the sweep and in the clr_start cycle.
    assign serve_en = !rst && (state == ST_SERVE) && !bus.clr_start;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (serve_en),
        .req_a (bus.a_valid),
        .req_b (bus.b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;
    assign rd_acc      = (gnt_a && !bus.a_write) || (gnt_b && !bus.b_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_SERVE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        unique case (state)
            ST_CLEAR: begin
                if (clr_cnt == CNT_LAST) begin
                    state_nxt   = ST_SERVE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            ST_SERVE: begin
                if (bus.clr_start) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: state_nxt = ST_SERVE;
        endcase
    end

    // Memory mux; everything is held at zero while rst is asserted.
    always_comb begin
        bus.busy        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        if (!rst) begin
            if (state == ST_CLEAR) begin
                bus.busy      = 1'b1;
                bus.mem_write = 1'b1;
                bus.mem_addr  = clr_cnt;
            end else if (gnt_a) begin
                bus.mem_read    = !bus.a_write;
                bus.mem_write   = bus.a_write;
                bus.mem_addr    = bus.a_addr;
                bus.mem_data_in = bus.a_write ? bus.a_wdata : '0;
            end else if (gnt_b) begin
                bus.mem_read    = !bus.b_write;
                bus.mem_write   = bus.b_write;
                bus.mem_addr    = bus.b_addr;
                bus.mem_data_in = bus.b_write ? bus.b_wdata : '0;
            end
        end
    end

    // Stage p1: pending read owner, lines up with memory read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= REQ_A;
        end else begin
            rd_vld_p1 <= rd_acc;
            rd_id_p1  <= gnt_b ? REQ_B : REQ_A;
        end
    end

    assign bus.a_rvalid = rd_vld_p1 && (rd_id_p1 == REQ_A);
    assign bus.b_rvalid = rd_vld_p1 && (rd_id_p1 == REQ_B);
    assign bus.a_rdata  = bus.a_rvalid ? bus.mem_data_out : '0;
    assign bus.b_rdata  = bus.b_rvalid ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random traffic
// compared every cycle against a behavioural model of grants, memory and sweep.
module tb_memory_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic clk;
    logic rst;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the arbiter: synchronous, 1-cycle read latency.
    logic [DW-1:0] tb_mem [DEPTH];
    logic [DW-1:0] mem_q;
    bit            preload;

    function automatic logic [DW-1:0] preload_val(int i);
        return 8'(i * 7 + 3) | 8'h80;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= preload_val(i);
        end else begin
            if (bus.mem_write) tb_mem[bus.mem_addr] <= bus.mem_data_in;
            if (bus.mem_read)  mem_q <= tb_mem[bus.mem_addr];
        end
    end
    assign bus.mem_data_out = mem_q;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Requester state (index 0 = A, 1 = B): held until granted.
    bit            req_v [2];
    bit            req_w [2];
    logic [AW-1:0] req_a [2];
    logic [DW-1:0] req_d [2];
    bit            clr;

    // Reference model.
    logic [DW-1:0] mm [DEPTH];
    int            clr_idx;
    int            ptr;
    bit            pend_v;
    int            pend_id;
    logic [DW-1:0] pend_d;

    task automatic model_reset();
        clr_idx = 0;
        ptr     = 0;
        pend_v  = 0;
        req_v[0] = 0;
        req_v[1] = 0;
        clr     = 0;
    endtask

    task automatic drive();
        bus.clr_start = clr;
        bus.a_valid = req_v[0]; bus.a_write = req_w[0]; bus.a_addr = req_a[0]; bus.a_wdata = req_d[0];
        bus.b_valid = req_v[1]; bus.b_write = req_w[1]; bus.b_addr = req_a[1]; bus.b_wdata = req_d[1];
    endtask

    task automatic check_zero(string tag);
        check_eq({tag, "_busy"},   bus.busy, 0);
        check_eq({tag, "_ready"},  {bus.a_ready, bus.b_ready}, 0);
        check_eq({tag, "_rvalid"}, {bus.a_rvalid, bus.b_rvalid}, 0);
        check_eq({tag, "_rdata"},  {bus.a_rdata, bus.b_rdata}, 0);
        check_eq({tag, "_mem_rw"}, {bus.mem_read, bus.mem_write}, 0);
        check_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
        check_eq({tag, "_mem_din"},  bus.mem_data_in, 0);
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance model at posedge.
    task automatic step();
        int  g;
        bit  exp_wr, exp_rd;
        drive();
        @(negedge clk);
        g = -1;
        if (clr_idx < 0 && !clr) begin
            if (req_v[0] && req_v[1]) g = ptr;
            else if (req_v[0])        g = 0;
            else if (req_v[1])        g = 1;
        end
        exp_wr = (clr_idx >= 0) || (g >= 0 && req_w[g]);
        exp_rd = (g >= 0) && !req_w[g];
        check_eq("busy",      bus.busy, clr_idx >= 0);
        check_eq("a_ready",   bus.a_ready, g == 0);
        check_eq("b_ready",   bus.b_ready, g == 1);
        check_eq("mem_write", bus.mem_write, exp_wr);
        check_eq("mem_read",  bus.mem_read, exp_rd);
        if (clr_idx >= 0) begin
            check_eq("clr_addr", bus.mem_addr, clr_idx);
            check_eq("clr_data", bus.mem_data_in, 0);
        end else if (g >= 0) begin
            check_eq("mem_addr", bus.mem_addr, req_a[g]);
            if (req_w[g]) check_eq("mem_data_in", bus.mem_data_in, req_d[g]);
        end
        check_eq("a_rvalid", bus.a_rvalid, pend_v && pend_id == 0);
        check_eq("b_rvalid", bus.b_rvalid, pend_v && pend_id == 1);
        check_eq("a_rdata",  bus.a_rdata, (pend_v && pend_id == 0) ? pend_d : 8'h00);
        check_eq("b_rdata",  bus.b_rdata, (pend_v && pend_id == 1) ? pend_d : 8'h00);
        @(posedge clk);
        pend_v = 0;
        if (clr_idx >= 0) begin
            mm[clr_idx] = '0;
            clr_idx++;
            if (clr_idx == DEPTH) clr_idx = -1;
        end else if (clr) begin
            clr_idx = 0;
        end else if (g >= 0) begin
            if (req_w[g]) begin
                mm[req_a[g]] = req_d[g];
            end else begin
                pend_v  = 1;
                pend_id = g;
                pend_d  = mm[req_a[g]];
            end
            ptr = 1 - g;
            req_v[g] = 0;
        end
        clr = 0;
        #1;
    endtask

    task automatic set_req(int r, bit w, int addr, logic [DW-1:0] d);
        req_v[r] = 1;
        req_w[r] = w;
        req_a[r] = AW'(addr);
        req_d[r] = d;
    endtask

    // Step until requesters and sweep are idle, bounded.
    task automatic drain(int max_cycles);
        int n = 0;
        while ((req_v[0] || req_v[1] || pend_v || clr_idx >= 0) && n < max_cycles) begin
            step();
            n++;
        end
        check_eq("drain_idle", {req_v[0], req_v[1], pend_v, clr_idx >= 0}, 0);
    endtask

    initial begin
        rst     = 1'b1;
        preload = 1'b1;
        for (int i = 0; i < DEPTH; i++) mm[i] = preload_val(i);
        for (int r = 0; r < 2; r++) begin
            req_w[r] = 0; req_a[r] = '0; req_d[r] = '0;
        end
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Power-up sweep, then confirm a few locations read back zero.
        drain(40);
        for (int i = 0; i < DEPTH; i += 9) begin
            set_req(i % 2, 0, i, 8'h00);
            drain(10);
        end

        // Both requesters valid together: grants alternate.
        set_req(0, 1, 3, 8'h11);
        set_req(1, 1, 4, 8'h22);
        drain(10);
        set_req(0, 0, 3, 8'h00);
        set_req(1, 0, 4, 8'h00);
        drain(10);

        // A writes then reads back the same address on consecutive cycles.
        set_req(0, 1, 5, 8'hA5);
        step();
        set_req(0, 0, 5, 8'h00);
        drain(10);

        // Fill every address, then clear with a request waiting on A.
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 1, i, 8'(i));
            drain(10);
        end
        set_req(0, 0, 17, 8'h00);
        clr = 1;
        drain(50);
        for (int i = 0; i < DEPTH; i++) begin
            set_req(i % 2, 0, i, 8'h00);
            drain(10);
        end

        // Read accepted, clr_start in the following cycle.
        set_req(1, 1, 7, 8'h5C);
        drain(10);
        set_req(1, 0, 7, 8'h00);
        step();
        clr = 1;
        drain(50);

        // Random traffic with occasional clears.
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_v[r] && $urandom_range(0, 3) != 0) begin
                    set_req(r, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1),
                            8'($urandom));
                end
            end
            clr = ($urandom_range(0, 99) == 0);
            step();
        end
        drain(60);

        // Reset in the middle of a sweep.
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1, 1, i, 8'hC0 | 8'(i));
            drain(10);
        end
        clr = 1;
        step();
        for (int n = 0; n < 40 && clr_idx != 10; n++) step();
        check_eq("sweep_at_10", clr_idx, 10);
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        drain(40);
        for (int i = 0; i < DEPTH; i++) begin
            set_req(0, 0, i, 8'h00);
            drain(10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
